spi_slave_port: RTL and testbench

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

---
 rtl/spi_slave_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_port.sv | 169 ++++++++++++++++
 tb/tb_spi_slave_port.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Register map and status/control bit positions for the SPI slave port.
package spi_slave_pkg;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int ST_ROE  = 3;
  localparam int ST_TOE  = 4;
  localparam int ST_TUE  = 5;
  localparam int ST_TRDY = 6;
  localparam int ST_RRDY = 7;
  localparam int ST_E    = 8;
  localparam int ST_SEL  = 9;

  // Interrupt-enable window in control, aligned with the status bits it gates.
  localparam int IRQ_LO = 3;
  localparam int IRQ_HI = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// generated on the synchronized level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE        = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{IDLE}};
      prev_q <= IDLE;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave with a 16-bit CPU register port (rxdata, txdata, status, control).
// Serial pins are resynchronised into clk; all shifting runs on detected SCLK edges.
module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);
  localparam int CNT_W   = (DATABITS > 1) ? $clog2(DATABITS) : 1;
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ss_s, ss_rise_unused, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sclk (
    .clk(clk), .reset_n(reset_n), .din(SCLK),
    .dout(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1)) u_ss (
    .clk(clk), .reset_n(reset_n), .din(SS_n),
    .dout(ss_s), .rise(ss_rise_unused), .fall(ss_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0)) u_mosi (
    .clk(clk), .reset_n(reset_n), .din(MOSI),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic [FLUSH_W-1:0]      flush_q;
  logic                    armed_q;
  logic                    rd_prev_q, wr_prev_q;
  logic                    primed_q, rrdy_q, roe_q, toe_q, tue_q;
  logic [IRQ_HI:IRQ_LO]    ctrl_q;
  logic [DATABITS-1:0]     tx_shift_q, tx_holding_q, rx_shift_q, rx_holding_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic                    word_done_q;

  logic flushed, selected, frame_start;
  logic rd_act, wr_act, rd_stb, wr_stb;
  logic wr_tx, wr_st, wr_ctl, rd_rx;
  logic word_in, tx_load, tx_adv;
  logic [DATABITS-1:0] rx_next;
  logic [15:0] status, rd_data;

  // A frame may only begin after SS_n has been seen high once the synchronizer
  // holds real samples, so a reset released mid-frame cannot fake an SS_n fall.
  assign flushed     = (flush_q == FLUSH_DONE);
  assign selected    = armed_q & ~ss_s;
  assign frame_start = armed_q & ss_fall;

  assign rd_act = spi_select & ~read_n;
  assign wr_act = spi_select & ~write_n;
  assign rd_stb = rd_act & ~rd_prev_q;
  assign wr_stb = wr_act & ~wr_prev_q;
  assign wr_tx  = wr_stb & (mem_addr == ADDR_TXDATA);
  assign wr_st  = wr_stb & (mem_addr == ADDR_STATUS);
  assign wr_ctl = wr_stb & (mem_addr == ADDR_CONTROL);
  assign rd_rx  = rd_stb & (mem_addr == ADDR_RXDATA);

  assign rx_next = (rx_shift_q << 1) | DATABITS'(mosi_s);
  assign word_in = selected & sclk_rise & (bit_cnt_q == CNT_W'(DATABITS - 1));
  // The fall that closes a word reloads the transmitter instead of shifting it.
  assign tx_load = frame_start | (selected & sclk_fall & word_done_q);
  assign tx_adv  = selected & sclk_fall & ~word_done_q;

  always_comb begin
    status          = '0;
    status[ST_ROE]  = roe_q;
    status[ST_TOE]  = toe_q;
    status[ST_TUE]  = tue_q;
    status[ST_TRDY] = ~primed_q;
    status[ST_RRDY] = rrdy_q;
    status[ST_E]    = roe_q | toe_q | tue_q;
    status[ST_SEL]  = selected;
  end

  always_comb begin
    rd_data = '0;
    case (mem_addr)
      ADDR_RXDATA:  rd_data[DATABITS-1:0]  = rx_holding_q;
      ADDR_STATUS:  rd_data                = status;
      ADDR_CONTROL: rd_data[IRQ_HI:IRQ_LO] = ctrl_q;
      default:      rd_data                = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_q     <= '0;
      armed_q     <= 1'b0;
      rd_prev_q   <= 1'b0;
      wr_prev_q   <= 1'b0;
      primed_q    <= 1'b0;
      rrdy_q      <= 1'b0;
      roe_q       <= 1'b0;
      toe_q       <= 1'b0;
      tue_q       <= 1'b0;
      ctrl_q      <= '0;
      irq         <= 1'b0;
      data_to_cpu <= '0;
    end else begin
      if (!flushed) flush_q <= flush_q + FLUSH_W'(1);
      armed_q   <= armed_q | (flushed & ss_s);
      rd_prev_q <= rd_act;
      wr_prev_q <= wr_act;
      // Sets take priority over same-cycle clears.
      primed_q <= (primed_q & ~tx_load) | (wr_tx & ~primed_q);
      rrdy_q   <= word_in | (rrdy_q & ~(wr_st | rd_rx));
      roe_q    <= (word_in & rrdy_q) | (roe_q & ~wr_st);
      toe_q    <= (wr_tx & primed_q) | (toe_q & ~wr_st);
      tue_q    <= (tx_load & ~primed_q) | (tue_q & ~wr_st);
      if (wr_ctl) ctrl_q <= data_from_cpu[IRQ_HI:IRQ_LO];
      irq <= |(status[IRQ_HI:IRQ_LO] & ctrl_q);
      if (rd_stb) data_to_cpu <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift_q   <= '0;
      tx_holding_q <= '0;
      rx_shift_q   <= '0;
      rx_holding_q <= '0;
      bit_cnt_q    <= '0;
      word_done_q  <= 1'b0;
    end else begin
      if (wr_tx && !primed_q) tx_holding_q <= data_from_cpu[DATABITS-1:0];
      if (tx_load)     tx_shift_q <= primed_q ? tx_holding_q : '0;
      else if (tx_adv) tx_shift_q <= tx_shift_q << 1;
      if (!selected) begin
        bit_cnt_q   <= '0;
        word_done_q <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift_q <= rx_next;
          bit_cnt_q  <= word_in ? '0 : bit_cnt_q + CNT_W'(1);
        end
        if (word_in) begin
          rx_holding_q <= rx_next;
          word_done_q  <= 1'b1;
        end else if (sclk_fall) begin
          word_done_q <= 1'b0;
        end
      end
    end
  end

  assign MISO          = selected & tx_shift_q[DATABITS-1];
  assign dataavailable = rrdy_q;
  assign readyfordata  = ~primed_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the register and frame behaviour.
module tb_spi_slave_port;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
  logic        spi_select = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [2:0]  mem_addr = '0;
  logic [15:0] data_from_cpu = '0;
  logic        MISO, irq, dataavailable, readyfordata;
  logic [15:0] data_to_cpu;

  spi_slave_port #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .spi_select(spi_select), .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .irq(irq),
    .dataavailable(dataavailable), .readyfordata(readyfordata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit quiet    = 1'b0;

  // Model state
  bit         m_primed, m_rrdy, m_roe, m_toe, m_tue;
  logic [7:0] m_hold, m_rx;
  logic [5:0] m_ctrl;

  logic [7:0] mw [4];
  logic [7:0] sw [4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_tue = 0;
    m_hold = '0; m_rx = '0; m_ctrl = '0;
  endfunction

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[3] = m_roe; s[4] = m_toe; s[5] = m_tue;
    s[6] = !m_primed; s[7] = m_rrdy; s[8] = m_roe | m_toe | m_tue;
    return s;
  endfunction

  function automatic bit m_irq();
    logic [15:0] s;
    s = m_status();
    return |(s[8:3] & m_ctrl);
  endfunction

  // Word handed to the shifter at frame start and at each word boundary.
  function automatic logic [7:0] m_load();
    logic [7:0] v;
    if (m_primed) begin v = m_hold; m_primed = 0; end
    else begin v = 8'h00; m_tue = 1; end
    return v;
  endfunction

  function automatic void m_word(input logic [7:0] w);
    if (m_rrdy) m_roe = 1;
    m_rrdy = 1;
    m_rx = w;
  endfunction

  always @(negedge clk) begin
    if (quiet) begin
      check("rrdy_pin", 16'(dataavailable), 16'(m_rrdy));
      check("trdy_pin", 16'(readyfordata), 16'(!m_primed));
      check("irq_pin", 16'(irq), 16'(m_irq()));
      check("miso_idle", 16'(MISO), 16'h0000);
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    quiet = 0;
    @(posedge clk); #1;
    spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    write_n = 1; spi_select = 0;
    case (a)
      3'd1: if (m_primed) m_toe = 1; else begin m_hold = d[7:0]; m_primed = 1; end
      3'd2: begin m_roe = 0; m_toe = 0; m_tue = 0; m_rrdy = 0; end
      3'd3: m_ctrl = d[8:3];
      default: ;
    endcase
    repeat (2) @(posedge clk); #1;
    quiet = 1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    quiet = 0;
    @(posedge clk); #1;
    spi_select = 1; read_n = 0; mem_addr = a;
    @(posedge clk); #1;
    d = data_to_cpu;
    @(posedge clk); #1;
    read_n = 1; spi_select = 0;
    if (a == 3'd0) m_rrdy = 0;
    repeat (2) @(posedge clk); #1;
    quiet = 1;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // Mode-0 master at clk/8; nbits < 8*nwords ends the frame early, rst_mid pulses reset there.
  task automatic spi_frame(input int nwords, input int nbits, input bit rst_mid);
    int total;
    total = (nbits > 0) ? nbits : nwords * 8;
    quiet = 0;
    @(posedge clk); #1;
    SS_n = 0;
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < total; i++) begin
      MOSI = mw[i/8][7 - i%8];
      repeat (4) @(posedge clk); #1;
      sw[i/8][7 - i%8] = MISO;
      SCLK = 1;
      repeat (4) @(posedge clk); #1;
      SCLK = 0;
    end
    if (rst_mid) begin
      check("miso_before_reset", 16'(MISO), 16'h0001);
      reset_n = 0;
      repeat (2) @(posedge clk); #1;
      check("miso_in_reset", 16'(MISO), 16'h0000);
      check("dout_in_reset", data_to_cpu, 16'h0000);
      reset_n = 1;
      m_reset();
      repeat (6) @(posedge clk); #1;
      check("miso_after_reset_ss_low", 16'(MISO), 16'h0000);
    end
    repeat (4) @(posedge clk); #1;
    SS_n = 1; MOSI = 0;
    repeat (8) @(posedge clk); #1;
  endtask

  task automatic frame_and_check(input string name, input int nwords);
    logic [7:0] exp [5];
    exp[0] = m_load();
    for (int w = 0; w < nwords; w++) begin
      m_word(mw[w]);
      exp[w+1] = m_load();
    end
    spi_frame(nwords, 0, 1'b0);
    for (int w = 0; w < nwords; w++) check(name, 16'(sw[w]), 16'(exp[w]));
    quiet = 1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    int nw, nt;
    m_reset();
    @(negedge clk);
    check("reset_dout", data_to_cpu, 16'h0000);
    check("reset_irq", 16'(irq), 16'h0000);
    check("reset_miso", 16'(MISO), 16'h0000);
    check("reset_rrdy", 16'(dataavailable), 16'h0000);
    check("reset_trdy", 16'(readyfordata), 16'h0001);
    @(posedge clk); #1;
    reset_n = 1;
    repeat (10) @(posedge clk); #1;
    quiet = 1;
    rd_check("reset_status", 3'd2, 16'h0040);

    // Basic transfer with RRDY interrupt enabled
    bus_write(3'd3, 16'h0080);
    rd_check("control_rb", 3'd3, 16'h0080);
    bus_write(3'd1, 16'h00A5);
    mw[0] = 8'h3C;
    frame_and_check("req033_model", 1);
    check("req033_miso", 16'(sw[0]), 16'h00A5);
    check("req033_irq", 16'(irq), 16'h0001);
    rd_check("req033_status", 3'd2, 16'h01E0);
    rd_check("req033_rx", 3'd0, 16'h003C);
    check("req033_rrdy_clr", 16'(dataavailable), 16'h0000);

    // Overrun
    bus_write(3'd2, 16'h0000);
    mw[0] = 8'h11; mw[1] = 8'h22;
    frame_and_check("req034_model", 2);
    rd_check("req034_status", 3'd2, 16'h01E8);
    bus_write(3'd2, 16'h0000);
    rd_check("req034_cleared", 3'd2, 16'h0040);
    rd_check("req034_rx", 3'd0, 16'h0022);

    // Underrun, then transmit overflow
    mw[0] = 8'h55;
    frame_and_check("req035_model", 1);
    check("req035_miso_zero", 16'(sw[0]), 16'h0000);
    rd_check("req035_tue", 3'd2, 16'h01E0);
    bus_write(3'd2, 16'h0000);
    bus_write(3'd1, 16'h005A);
    bus_write(3'd1, 16'h00C3);
    rd_check("req035_toe", 3'd2, 16'h0110);
    mw[0] = 8'h99;
    frame_and_check("req035_model2", 1);
    check("req035_first_kept", 16'(sw[0]), 16'h005A);

    // Aborted frame
    bus_write(3'd2, 16'h0000);
    mw[0] = 8'hFF;
    void'(m_load());
    spi_frame(1, 5, 1'b0);
    quiet = 1;
    check("req036_rrdy", 16'(dataavailable), 16'h0000);
    mw[0] = 8'h81;
    frame_and_check("req036_model", 1);
    rd_check("req036_rx", 3'd0, 16'h0081);

    // Reset in the middle of a frame (3C shifted 3 times leaves MISO high)
    bus_write(3'd2, 16'h0000);
    bus_write(3'd1, 16'h003C);
    mw[0] = 8'hF0;
    void'(m_load());
    spi_frame(1, 3, 1'b1);
    quiet = 1;
    rd_check("req037_status", 3'd2, 16'h0040);
    mw[0] = 8'h7E;
    frame_and_check("req037_model", 1);
    rd_check("req037_rx", 3'd0, 16'h007E);
    rd_check("unmapped", 3'd5, 16'h0000);

    // Randomized traffic
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) bus_write(3'd3, 16'($urandom));
      nt = $urandom_range(0, 2);
      for (int k = 0; k < nt; k++) bus_write(3'd1, 16'($urandom));
      for (int w = 0; w < 4; w++) mw[w] = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        void'(m_load());
        spi_frame(1, $urandom_range(1, 7), 1'b0);
        quiet = 1;
      end else begin
        nw = $urandom_range(1, 3);
        frame_and_check("rand_miso", nw);
      end
      rd_check("rand_status", 3'd2, m_status());
      if ($urandom_range(0, 1) == 1) rd_check("rand_rx", 3'd0, {8'h00, m_rx});
      if ($urandom_range(0, 2) == 0) bus_write(3'd2, 16'h0000);
      rd_check("rand_ctrl", 3'd3, {7'b0, m_ctrl, 3'b0});
    end

    quiet = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
